adder_result_collector: RTL and testbench
=========================================

Name: adder_result_collector

Overview:
- Sits directly downstream of the DPI-backed 16-bit adder stage and captures each 17-bit sum it produces when the upstream sequencer flags it valid.
- Buffers captured sums in a small FIFO and releases them on a valid/ready interface to the checker/scoreboard stage.
- Maintains running statistics for the test harness: a saturating accumulator of all accepted sums, a carry-out count and a dropped-sum count.
- The adder has no backpressure, so sums arriving while the FIFO is full are dropped and counted.

Parameters:
- DEPTH, 4: FIFO entries; must be a power of two and at least 2.
- SUM_W, 17: width of one sum; the MSB is the adder carry-out.
- ACC_W, 32: accumulator width.
- CNT_W, 16: width of the carry and drop counters.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  i_sum is a fresh adder result this cycle
- i_sum  input  SUM_W  adder result
- i_clr  input  1  synchronous clear of statistics (FIFO contents untouched)
- o_valid  output  1  FIFO head valid
- o_sum  output  SUM_W  FIFO head data
- i_ready  input  1  downstream accepts the head this cycle
- o_acc  output  ACC_W  saturating sum of all accepted i_sum values
- o_carry_cnt  output  CNT_W  accepted sums with MSB=1, saturating
- o_drop_cnt  output  CNT_W  rejected i_valid cycles, saturating
- o_level  output  $clog2(DEPTH)+1  current FIFO occupancy
- o_full  output  1  occupancy == DEPTH
- o_empty  output  1  occupancy == 0

Behaviour:
- Reset, asynchronous, rst_n low:
  - All pointers, counters and o_acc go to 0.
  - o_valid=0, o_sum=0, o_level=0, o_full=0, o_empty=1.
  - Asserting reset mid-stream discards FIFO contents immediately, with no partial output.
- pop = o_valid & i_ready.
- push = i_valid & (!o_full | pop): the write into a full FIFO is accepted when a pop happens in the same cycle.
- drop = i_valid & !push.
- Latency: a sum pushed at edge N is visible on o_sum/o_valid after edge N, i.e. registered and one cycle. There is no combinational path from i_valid to o_valid.
- o_sum holds the head entry while o_valid=1 and i_ready=0; both must stay stable under backpressure.
- When empty, o_sum holds its last value and is ignored.
- Pointers:
  - Read and write pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - full = MSBs differ and the low bits are equal; empty = pointers equal.
- Occupancy FSM, derived from the pointers:
  - States EMPTY, PARTIAL, FULL.
  - EMPTY to PARTIAL on push without pop.
  - PARTIAL to FULL when the level reaches DEPTH.
  - FULL to PARTIAL on pop without push.
  - Push and pop together leave the level unchanged in every state.
  - Push and pop together while EMPTY is impossible, since pop requires o_valid.
- Accumulator:
  - On push, o_acc <= min(o_acc + zero-extended i_sum, 2^ACC_W-1).
  - The sum is computed in ACC_W+1 bits before saturation.
- Counters:
  - o_carry_cnt increments on push when i_sum[SUM_W-1]=1.
  - o_drop_cnt increments on drop.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- i_clr:
  - Statistics are zeroed first, then the same cycle's event is applied.
  - Example: i_clr with a push of 0x1_0002 gives o_acc=0x1_0002 and o_carry_cnt=1. i_clr with a drop gives o_drop_cnt=1.
- i_clr does not affect FIFO state or o_valid.

Decomposition:
- Package adder_result_pkg:
  - localparam SUM_W=17.
  - typedef logic [SUM_W-1:0] sum_t.
  - typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_state_e.
  - A saturating-increment function reused by both counters.
- One sub-module, result_fifo:
  - Parameterised DEPTH and data type.
  - Contains the storage, pointers, level and full/empty flags, and the occupancy FSM.
- The top level holds the push/drop logic, the accumulator and the counters.

Test Plan:
- Reset then push 0x0_0003, 0x1_FFFE, 0x0_0001 back-to-back with i_ready=1 -> o_sum sequence matches one cycle later; o_acc=0x2_0002, o_carry_cnt=1, o_drop_cnt=0, o_empty=1 at the end.
- Hold i_ready=0 and push 6 sums with DEPTH=4 -> o_full=1 after the 4th push; o_drop_cnt=2; o_sum stays at the first value; on release, exactly the 4 oldest sums drain in order.
- FIFO full, i_ready=1, push every cycle for 10 cycles -> zero drops; o_level stays at 4; output order matches input order across pointer wrap.
- Preload o_acc near saturation with 0x1_FFFF pushes (ACC_W=18 build) -> o_acc sticks at 0x3_FFFF; further pushes leave it unchanged.
- i_clr asserted on the same cycle as a push of 0x1_0005 -> o_acc=0x1_0005 and o_carry_cnt=1 next cycle; FIFO level increments normally.
- Deassert rst_n mid-drain with o_level=3 -> o_valid falls without waiting for a clock edge; after release, o_level=0, all statistics are 0, and the next push appears with 1-cycle latency.

Source files
------------

// File: rtl/adder_result_pkg.sv
// Shared types and helpers for the adder result collector.
//   SUM_W        : width of one adder result, MSB is the adder carry-out
//   sum_t        : one adder result
//   occ_state_e  : occupancy state of the result FIFO
//   sat_inc      : increment that sticks at a maximum value instead of wrapping
`timescale 1ns/1ps
package adder_result_pkg;

    localparam int SUM_W = 17;

    typedef logic [SUM_W-1:0] sum_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_state_e;

    // Counters narrower than 32 bits pass their zero-extended value and
    // all-ones maximum, then truncate the result back to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding captured adder results.
//   clk, rst_n : clock and asynchronous active-low reset
//   push/wdata : write one entry (caller guarantees room, or a same-cycle pop)
//   pop        : remove the head entry (caller guarantees valid)
//   valid/rdata: head entry; rdata holds the last popped value while empty
//   level      : occupancy, full/empty flags derived from the pointers
`timescale 1ns/1ps
module result_fifo
    import adder_result_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = sum_t,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  T                 wdata,
    input  logic             pop,
    output logic             valid,
    output T                 rdata,
    output logic [PTR_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int IDX_W = PTR_W - 1;

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    T                 last_q;
    T                 last_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    occ_state_e       state_q;
    occ_state_e       state_d;

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign wr_idx = wr_ptr_q[IDX_W-1:0];
    assign rd_idx = rd_ptr_q[IDX_W-1:0];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_idx == rd_idx);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign valid = (state_q != OCC_EMPTY);
    assign rdata = valid ? mem_q[rd_idx] : last_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        if (push) begin
            mem_d[wr_idx] = wdata;
            wr_ptr_d      = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            // Remember the departing head so rdata stays put once empty.
            last_d   = mem_q[rd_idx];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // Occupancy FSM; simultaneous push and pop never change the level.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OCC_EMPTY: begin
                if (push && !pop) state_d = OCC_PARTIAL;
            end
            OCC_PARTIAL: begin
                if (push && !pop && level == PTR_W'(DEPTH - 1)) state_d = OCC_FULL;
                else if (pop && !push && level == PTR_W'(1))    state_d = OCC_EMPTY;
            end
            OCC_FULL: begin
                if (pop && !push) state_d = OCC_PARTIAL;
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            last_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= OCC_EMPTY;
        end else begin
            mem_q    <= mem_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
        end
    end

endmodule

// File: rtl/adder_result_collector.sv
// Captures adder results into a FIFO for the downstream checker and keeps
// running statistics for the test harness.
//   clk, rst_n        : clock and asynchronous active-low reset
//   i_valid, i_sum    : adder result strobe and data (no backpressure)
//   i_clr             : zero statistics, then apply this cycle's event
//   o_valid, o_sum    : FIFO head, accepted when i_ready is high
//   o_acc             : saturating sum of accepted results
//   o_carry_cnt       : accepted results with carry-out set, saturating
//   o_drop_cnt        : results lost to a full FIFO, saturating
//   o_level/full/empty: FIFO occupancy
`timescale 1ns/1ps
module adder_result_collector
    import adder_result_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SUM_W = 17,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_valid,
    input  logic [SUM_W-1:0]           i_sum,
    input  logic                       i_clr,
    output logic                       o_valid,
    output logic [SUM_W-1:0]           o_sum,
    input  logic                       i_ready,
    output logic [ACC_W-1:0]           o_acc,
    output logic [CNT_W-1:0]           o_carry_cnt,
    output logic [CNT_W-1:0]           o_drop_cnt,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    logic             pop;
    logic             push;
    logic             drop;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] carry_q;
    logic [CNT_W-1:0] carry_d;
    logic [CNT_W-1:0] drop_q;
    logic [CNT_W-1:0] drop_d;

    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   acc_sum;
    logic [CNT_W-1:0] carry_base;
    logic [CNT_W-1:0] drop_base;

    // A full FIFO still takes a write when its head leaves in the same cycle.
    assign pop  = o_valid & i_ready;
    assign push = i_valid & (~o_full | pop);
    assign drop = i_valid & ~push;

    result_fifo #(
        .DEPTH (DEPTH),
        .T     (logic [SUM_W-1:0])
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (i_sum),
        .pop   (pop),
        .valid (o_valid),
        .rdata (o_sum),
        .level (o_level),
        .full  (o_full),
        .empty (o_empty)
    );

    // Clear acts first, so a cleared cycle still records its own push/drop.
    always_comb begin
        acc_base   = i_clr ? '0 : acc_q;
        carry_base = i_clr ? '0 : carry_q;
        drop_base  = i_clr ? '0 : drop_q;

        acc_sum = {1'b0, acc_base} + (ACC_W + 1)'(i_sum);

        acc_d   = acc_base;
        carry_d = carry_base;
        drop_d  = drop_base;

        if (push) begin
            acc_d = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
            if (i_sum[SUM_W-1]) begin
                carry_d = CNT_W'(sat_inc(32'(carry_base), CNT_MAX));
            end
        end
        if (drop) begin
            drop_d = CNT_W'(sat_inc(32'(drop_base), CNT_MAX));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            carry_q <= '0;
            drop_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            drop_q  <= drop_d;
        end
    end

    assign o_acc       = acc_q;
    assign o_carry_cnt = carry_q;
    assign o_drop_cnt  = drop_q;

endmodule

// File: tb/tb_adder_result_collector.sv
`timescale 1ns/1ps
module tb_adder_result_collector;

    localparam int DEPTH = 4;
    localparam int SUM_W = 17;
    localparam int ACC_W = 18;
    localparam int CNT_W = 16;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             i_valid;
    logic [SUM_W-1:0] i_sum;
    logic             i_clr;
    logic             o_valid;
    logic [SUM_W-1:0] o_sum;
    logic             i_ready;
    logic [ACC_W-1:0] o_acc;
    logic [CNT_W-1:0] o_carry_cnt;
    logic [CNT_W-1:0] o_drop_cnt;
    logic [LVL_W-1:0] o_level;
    logic             o_full;
    logic             o_empty;

    int total = 0;
    int bad   = 0;

    logic [SUM_W-1:0] exp_q[$];
    int               model_level;
    longint           model_acc;
    longint           model_carry;
    longint           model_drop;
    bit               mon_en;

    adder_result_collector #(
        .DEPTH (DEPTH),
        .SUM_W (SUM_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .i_sum       (i_sum),
        .i_clr       (i_clr),
        .o_valid     (o_valid),
        .o_sum       (o_sum),
        .i_ready     (i_ready),
        .o_acc       (o_acc),
        .o_carry_cnt (o_carry_cnt),
        .o_drop_cnt  (o_drop_cnt),
        .o_level     (o_level),
        .o_full      (o_full),
        .o_empty     (o_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle, predict accept/drop from the reference model and
    // queue accepted sums; the model state advances after the clock edge.
    task automatic applyStimulus(input bit v, input logic [SUM_W-1:0] s, input bit r, input bit c);
        bit pop_m;
        bit push_m;
        i_valid = v;
        i_sum   = s;
        i_ready = r;
        i_clr   = c;
        pop_m   = r && (model_level > 0);
        push_m  = v && ((model_level < DEPTH) || pop_m);
        if (push_m) exp_q.push_back(s);
        @(posedge clk);
        #1;
        if (c) begin
            model_acc   = 0;
            model_carry = 0;
            model_drop  = 0;
        end
        if (push_m) begin
            model_acc = model_acc + longint'(s);
            if (model_acc > ACC_MAX) model_acc = ACC_MAX;
            if (s[SUM_W-1] && model_carry < CNT_MAX) model_carry++;
        end
        if (v && !push_m && model_drop < CNT_MAX) model_drop++;
        model_level = model_level + int'(push_m) - int'(pop_m);
    endtask

    task automatic modelClear();
        exp_q.delete();
        model_level = 0;
        model_acc   = 0;
        model_carry = 0;
        model_drop  = 0;
    endtask

    task automatic doReset();
        mon_en  = 0;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_sum   = '0;
        i_ready = 1'b0;
        i_clr   = 1'b0;
        @(posedge clk);
        modelClear();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && model_level > 0; i++) applyStimulus(0, '0, 1, 0);
        checkOutput("drain_done", longint'(model_level), 0);
    endtask

    // Monitor: mid-cycle, compare flags and statistics with the model and
    // check the FIFO head against the scoreboard, retiring it on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("level", longint'(o_level), longint'(model_level));
            checkOutput("valid", longint'(o_valid), longint'(model_level > 0));
            checkOutput("full",  longint'(o_full),  longint'(model_level == DEPTH));
            checkOutput("empty", longint'(o_empty), longint'(model_level == 0));
            checkOutput("acc",   longint'(o_acc), model_acc);
            checkOutput("carry", longint'(o_carry_cnt), model_carry);
            checkOutput("drops", longint'(o_drop_cnt), model_drop);
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL head_unexpected actual=0x%0h expected=none", o_sum);
                end else begin
                    checkOutput("head", longint'(o_sum), longint'(exp_q[0]));
                    if (i_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [SUM_W-1:0] vals[6];
        logic [SUM_W-1:0] s;
        mon_en  = 0;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_sum   = '0;
        i_ready = 1'b0;
        i_clr   = 1'b0;
        modelClear();
        #1;
        $display("[TB] reset values");
        checkOutput("rst_valid", longint'(o_valid), 0);
        checkOutput("rst_sum",   longint'(o_sum), 0);
        checkOutput("rst_level", longint'(o_level), 0);
        checkOutput("rst_full",  longint'(o_full), 0);
        checkOutput("rst_empty", longint'(o_empty), 1);
        checkOutput("rst_acc",   longint'(o_acc), 0);

        $display("[TB] back-to-back pushes");
        doReset();
        applyStimulus(1, 17'h0_0003, 1, 0);
        applyStimulus(1, 17'h1_FFFE, 1, 0);
        applyStimulus(1, 17'h0_0001, 1, 0);
        applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 1, 0);
        checkOutput("b2b_acc",   longint'(o_acc), 'h2_0002);
        checkOutput("b2b_carry", longint'(o_carry_cnt), 1);
        checkOutput("b2b_drop",  longint'(o_drop_cnt), 0);
        checkOutput("b2b_empty", longint'(o_empty), 1);
        checkOutput("b2b_sb",    longint'(exp_q.size()), 0);

        $display("[TB] backpressure overflow");
        doReset();
        vals = '{17'h0_0011, 17'h1_0022, 17'h0_0033, 17'h0_0044, 17'h1_0055, 17'h0_0066};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, vals[i], 0, 0);
            if (i == 3) checkOutput("bp_full4", longint'(o_full), 1);
        end
        checkOutput("bp_drop",  longint'(o_drop_cnt), 2);
        checkOutput("bp_head",  longint'(o_sum), longint'(vals[0]));
        checkOutput("bp_level", longint'(o_level), DEPTH);
        drain();

        $display("[TB] full with simultaneous push and pop");
        doReset();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, SUM_W'(32'h200 + i), 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, SUM_W'(32'h1_0100 + i), 1, 0);
        checkOutput("wrap_drop",  longint'(o_drop_cnt), 0);
        checkOutput("wrap_level", longint'(o_level), DEPTH);
        drain();

        $display("[TB] accumulator saturation");
        doReset();
        applyStimulus(1, 17'h1_FFFF, 1, 0);
        applyStimulus(1, 17'h1_FFFF, 1, 0);
        checkOutput("sat_pre", longint'(o_acc), 'h3_FFFE);
        applyStimulus(1, 17'h1_FFFF, 1, 0);
        checkOutput("sat_hit", longint'(o_acc), 'h3_FFFF);
        applyStimulus(1, 17'h0_0005, 1, 0);
        checkOutput("sat_hold", longint'(o_acc), 'h3_FFFF);
        drain();

        $display("[TB] clear coincident with push");
        doReset();
        applyStimulus(1, 17'h1_0007, 0, 0);
        applyStimulus(1, 17'h1_0005, 0, 1);
        checkOutput("clr_acc",   longint'(o_acc), 'h1_0005);
        checkOutput("clr_carry", longint'(o_carry_cnt), 1);
        checkOutput("clr_level", longint'(o_level), 2);
        for (int i = 0; i < 3; i++) applyStimulus(1, 17'h0_0009, 0, 0);
        applyStimulus(1, 17'h0_0001, 0, 1);
        checkOutput("clr_drop", longint'(o_drop_cnt), 1);
        drain();

        $display("[TB] random traffic");
        doReset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) s = SUM_W'($urandom_range(0, 255));
            else                           s = SUM_W'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, s, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 31) == 0);
        end
        drain();
        checkOutput("rand_sb", longint'(exp_q.size()), 0);

        $display("[TB] reset during drain");
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, SUM_W'(32'h0_0700 + i), 0, 0);
        checkOutput("mid_level3", longint'(o_level), 3);
        i_valid = 1'b0;
        i_ready = 1'b1;
        #2;
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        checkOutput("mid_valid_async", longint'(o_valid), 0);
        checkOutput("mid_level_async", longint'(o_level), 0);
        checkOutput("mid_empty_async", longint'(o_empty), 1);
        @(posedge clk);
        modelClear();
        #1;
        rst_n  = 1'b1;
        mon_en = 1;
        checkOutput("mid_acc",   longint'(o_acc), 0);
        checkOutput("mid_carry", longint'(o_carry_cnt), 0);
        checkOutput("mid_drop",  longint'(o_drop_cnt), 0);
        applyStimulus(1, 17'h1_0ABC, 0, 0);
        checkOutput("mid_lat_valid", longint'(o_valid), 1);
        checkOutput("mid_lat_sum",   longint'(o_sum), 'h1_0ABC);
        drain();

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
